mem_mp: RTL

Parametrised multi-port, byte-addressed, word-organised on-chip memory with valid/ready request channels, round-robin arbitration and a pipelined response path. It generalises the single-port strobed memory: several masters (core fetch, core LSU, debug/DMA) share one storage array. At most one access completes per cycle, and each master gets a fixed-latency response.

---
 rtl/mem_mp_pkg.sv | 26 ++
 rtl/mem_mp_rr_arbiter.sv | 52 +++++
 rtl/mem_mp.sv | 120 ++++++++++++
 3 files changed

// File: rtl/mem_mp_pkg.sv
// Shared derivations and helpers for the multi-port memory: row geometry and
// byte-address to row-index conversion.
package mem_mp_pkg;

  localparam int DEF_NUM_PORTS    = 2;
  localparam int DEF_ADDR_WIDTH   = 12;
  localparam int DEF_DATA_WIDTH   = 32;
  localparam int DEF_READ_LATENCY = 1;

  function automatic int num_row_bytes(input int data_width);
    return data_width / 8;
  endfunction

  function automatic int lg_row_bytes(input int data_width);
    return $clog2(data_width / 8);
  endfunction

  function automatic int mem_depth(input int addr_width, input int data_width);
    return 1 << (addr_width - lg_row_bytes(data_width));
  endfunction

  function automatic logic [31:0] row_index(input logic [31:0] addr, input int lg);
    return addr >> lg;
  endfunction

endpackage

// File: rtl/mem_mp_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or above the pointer,
// wrapping, and moves the pointer past the winner when the grant is taken.
module rr_arbiter #(
  parameter int N = 2,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk_i,
  input  logic          arst_i,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] ptr
);

  logic [PW-1:0] ptr_r;
  logic [PW-1:0] gnt_idx_s;
  logic [PW-1:0] ptr_next_s;
  logic          found_s;

  // Search upward from the pointer for the first active request.
  always_comb begin
    int   idx;
    logic hit;
    idx       = 0;
    hit       = 1'b0;
    gnt       = '0;
    gnt_idx_s = '0;
    found_s   = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx       = (int'(ptr_r) + i) % N;
      hit       = req[idx] & ~found_s;
      gnt[idx]  = hit;
      gnt_idx_s = hit ? PW'(idx) : gnt_idx_s;
      found_s   = found_s | hit;
    end
    ptr_next_s = (gnt_idx_s == PW'(N - 1)) ? '0 : gnt_idx_s + PW'(1);
  end

  // Pointer register; holds when nothing is granted.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      ptr_r <= '0;
    end else if (advance && found_s) begin
      ptr_r <= ptr_next_s;
    end else begin
      ptr_r <= ptr_r;
    end
  end

  assign ptr = ptr_r;

endmodule

// File: rtl/mem_mp.sv
// Multi-port byte-addressed memory: one arbitrated access per cycle into a
// shared row array, with a fixed-latency response pipeline demuxed by port.
module mem_mp
  import mem_mp_pkg::*;
#(
  parameter int NUM_PORTS    = DEF_NUM_PORTS,
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int READ_LATENCY = DEF_READ_LATENCY
) (
  input  logic                                          clk_i,
  input  logic                                          arst_i,
  input  logic [NUM_PORTS-1:0]                          req_valid_i,
  output logic [NUM_PORTS-1:0]                          req_ready_o,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]               req_addr_i,
  input  logic [NUM_PORTS-1:0]                          req_we_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]               req_wdata_i,
  input  logic [NUM_PORTS*num_row_bytes(DATA_WIDTH)-1:0] req_wstrb_i,
  output logic [NUM_PORTS-1:0]                          rsp_valid_o,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]               rsp_rdata_o
);

  localparam int NRB        = num_row_bytes(DATA_WIDTH);
  localparam int LGB        = lg_row_bytes(DATA_WIDTH);
  localparam int DEPTH_ROWS = mem_depth(ADDR_WIDTH, DATA_WIDTH);
  localparam int IDX_W      = ADDR_WIDTH - LGB;
  localparam int PID_W      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int LAST       = READ_LATENCY - 1;

  typedef struct packed {
    logic                  valid;
    logic [PID_W-1:0]      port_id;
    logic [DATA_WIDTH-1:0] data;
  } rsp_entry_t;

  logic [DATA_WIDTH-1:0] mem_r [DEPTH_ROWS];
  rsp_entry_t            pipe_r [READ_LATENCY];
  rsp_entry_t            entry_s;

  logic [NUM_PORTS-1:0]  gnt_s;
  logic [PID_W-1:0]      rr_ptr_unused_s;
  logic [PID_W-1:0]      gnt_id_s;
  logic                  accept_s;
  logic                  sel_we_s;
  logic [ADDR_WIDTH-1:0] sel_addr_s;
  logic [DATA_WIDTH-1:0] sel_wdata_s;
  logic [NRB-1:0]        sel_wstrb_s;
  logic [IDX_W-1:0]      row_s;
  logic [DATA_WIDTH-1:0] old_row_s;
  logic [DATA_WIDTH-1:0] merged_row_s;

  rr_arbiter #(.N(NUM_PORTS)) u_arb (
    .clk_i   (clk_i),
    .arst_i  (arst_i),
    .req     (req_valid_i),
    .advance (accept_s),
    .gnt     (gnt_s),
    .ptr     (rr_ptr_unused_s)
  );

  assign req_ready_o = gnt_s & {NUM_PORTS{~arst_i}};
  assign accept_s    = |req_ready_o;

  // Select the granted payload, merge bytes and form the pipeline entry.
  always_comb begin
    gnt_id_s    = '0;
    sel_we_s    = 1'b0;
    sel_addr_s  = '0;
    sel_wdata_s = '0;
    sel_wstrb_s = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      gnt_id_s    = gnt_s[p] ? PID_W'(p) : gnt_id_s;
      sel_we_s    = sel_we_s | (gnt_s[p] & req_we_i[p]);
      sel_addr_s  = sel_addr_s | ({ADDR_WIDTH{gnt_s[p]}} & req_addr_i[p*ADDR_WIDTH +: ADDR_WIDTH]);
      sel_wdata_s = sel_wdata_s | ({DATA_WIDTH{gnt_s[p]}} & req_wdata_i[p*DATA_WIDTH +: DATA_WIDTH]);
      sel_wstrb_s = sel_wstrb_s | ({NRB{gnt_s[p]}} & req_wstrb_i[p*NRB +: NRB]);
    end
    row_s        = IDX_W'(row_index(32'(sel_addr_s), LGB));
    old_row_s    = mem_r[row_s];
    merged_row_s = old_row_s;
    for (int b = 0; b < NRB; b++) begin
      merged_row_s[b*8 +: 8] = sel_wstrb_s[b] ? sel_wdata_s[b*8 +: 8] : old_row_s[b*8 +: 8];
    end
    entry_s.valid   = accept_s;
    entry_s.port_id = gnt_id_s;
    entry_s.data    = accept_s ? (sel_we_s ? merged_row_s : old_row_s) : '0;
  end

  // Storage array; contents deliberately survive reset.
  always_ff @(posedge clk_i) begin
    if (accept_s && sel_we_s) begin
      mem_r[row_s] <= merged_row_s;
    end
  end

  // Response shift register; reset drops everything in flight.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      for (int k = 0; k < READ_LATENCY; k++) begin
        pipe_r[k] <= '0;
      end
    end else begin
      pipe_r[0] <= entry_s;
      for (int k = 1; k < READ_LATENCY; k++) begin
        pipe_r[k] <= pipe_r[k-1];
      end
    end
  end

  // Demux the last stage to its port; idle ports read as zero.
  always_comb begin
    rsp_valid_o = '0;
    rsp_rdata_o = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      rsp_valid_o[p] = pipe_r[LAST].valid && (pipe_r[LAST].port_id == PID_W'(p));
      rsp_rdata_o[p*DATA_WIDTH +: DATA_WIDTH] = rsp_valid_o[p] ? pipe_r[LAST].data : '0;
    end
  end

endmodule
